// File: rtl/sp_req_queue_if.sv
// Request/response bundle between execute, the request queue and the scratchpad.
// The slave side is the queue; the master side is execute plus the scratchpad consumer.
interface sp_req_queue_if;
  logic        mls_valid;
  logic [1:0]  mls_ls;
  logic [3:0]  mls_rd;
  logic [31:0] mls_rs;
  logic [10:0] mls_imm;
  logic [4:0]  mls_stride;
  logic        mls_ready;
  logic        gemm_valid;
  logic        gemm_new_weight;
  logic [15:0] gemm_sel;
  logic        gemm_ready;
  logic        sp_valid;
  logic [42:0] sp_data;
  logic        sp_ready;

  modport master (
    output mls_valid, mls_ls, mls_rd, mls_rs, mls_imm, mls_stride,
    output gemm_valid, gemm_new_weight, gemm_sel, sp_ready,
    input  mls_ready, gemm_ready, sp_valid, sp_data
  );

  modport slave (
    input  mls_valid, mls_ls, mls_rd, mls_rs, mls_imm, mls_stride,
    input  gemm_valid, gemm_new_weight, gemm_sel, sp_ready,
    output mls_ready, gemm_ready, sp_valid, sp_data
  );
endinterface

// File: rtl/sp_req_queue.sv
// Packs MLS/GEMM requests into 43-bit entries and queues them in a
// first-word-fall-through FIFO feeding the scratchpad controller.
module sp_req_queue #(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  sp_req_queue_if.slave            bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     illegal_op
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [42:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          mls_legal;
  logic          mls_take;
  logic          mls_push;
  logic          gemm_push;
  logic          push;
  logic          pop;
  logic [31:0]   mls_addr;
  logic [42:0]   push_data;

  // Readiness comes only from registered count so a same-cycle pop never frees a slot.
  assign full           = (count == CW'(DEPTH));
  assign bus.mls_ready  = !full && !flush;
  assign bus.gemm_ready = !full && !flush && !bus.mls_valid;
  assign almost_full    = (count >= CW'(AF_THRESH));
  assign bus.sp_valid   = (count != '0);
  assign bus.sp_data    = mem[rd_ptr];

  assign mls_legal = (bus.mls_ls == 2'b01) || (bus.mls_ls == 2'b10);
  assign mls_take  = bus.mls_valid && bus.mls_ready;
  assign mls_push  = mls_take && mls_legal;
  assign gemm_push = bus.gemm_valid && bus.gemm_ready;
  assign push      = mls_push || gemm_push;
  assign pop       = bus.sp_valid && bus.sp_ready;

  assign mls_addr  = bus.mls_rs + {{21{bus.mls_imm[10]}}, bus.mls_imm};

  always_comb begin
    push_data = {2'b11, bus.gemm_new_weight, 3'b000, 16'd0, bus.gemm_sel, 5'd0};
    if (mls_push)
      push_data = {bus.mls_ls, bus.mls_rd, mls_addr, bus.mls_stride};
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= mls_take && !mls_legal;
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sp_req_queue.sv
// Directed bench for sp_req_queue: a scoreboard queue of expected entries is
// filled by the stimulus and drained by a monitor on every sp handshake.
module tb_sp_req_queue;
  logic       clk;
  logic       rst;
  logic       flush;
  logic [3:0] count;
  logic       almost_full;
  logic       illegal_op;

  sp_req_queue_if bus ();

  sp_req_queue #(.DEPTH(8), .AF_THRESH(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .count(count), .almost_full(almost_full), .illegal_op(illegal_op)
  );

  int n_vec  = 0;
  int n_fail = 0;
  logic [42:0] sb[$];

  logic [1:0]  fill_ls   [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] fill_rs   [8] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300,
                                 32'h1234_5678, 32'hFFFF_FFF0, 32'h0000_0010, 32'h8000_0000};
  logic [10:0] fill_imm  [8] = '{11'h000, 11'h001, 11'h3FF, 11'h400,
                                 11'h7FF, 11'h020, 11'h7E0, 11'h001};
  logic [31:0] fill_addr [8] = '{32'h0000_0000, 32'h0000_0101, 32'h0000_05FF, 32'hFFFF_FF00,
                                 32'h1234_5677, 32'h0000_0010, 32'hFFFF_FFF0, 32'h8000_0001};
  logic [4:0]  fill_st   [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd31};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mls_valid  = 1'b0;
    bus.gemm_valid = 1'b0;
  endtask

  task automatic apply_mls(input logic [1:0] ls, input logic [3:0] rd, input logic [31:0] rs,
                           input logic [10:0] imm, input logic [4:0] st);
    bus.mls_valid  = 1'b1;
    bus.mls_ls     = ls;
    bus.mls_rd     = rd;
    bus.mls_rs     = rs;
    bus.mls_imm    = imm;
    bus.mls_stride = st;
  endtask

  task automatic apply_gemm(input logic nw, input logic [15:0] sel);
    bus.gemm_valid      = 1'b1;
    bus.gemm_new_weight = nw;
    bus.gemm_sel        = sel;
  endtask

  task automatic drain();
    bus.sp_ready = 1'b1;
    for (int k = 0; k < 40 && count != 4'd0; k++)
      step();
    check_output("drain_done", 64'(count), 64'd0);
    bus.sp_ready = 1'b0;
  endtask

  // Monitor: every delivered head entry must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && count > 4'd8) begin
      n_fail++;
      $display("[TB] FAIL count_range: got %0d expected <= 8", count);
    end
    if (!rst && bus.sp_valid && bus.sp_ready) begin
      if (sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL sb_empty: got %h expected no entry", bus.sp_data);
      end else
        check_output("sp_data", 64'(bus.sp_data), 64'(sb.pop_front()));
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0;
    bus.sp_ready = 1'b0; bus.mls_valid = 1'b0; bus.gemm_valid = 1'b0;
    bus.mls_ls = '0; bus.mls_rd = '0; bus.mls_rs = '0; bus.mls_imm = '0; bus.mls_stride = '0;
    bus.gemm_new_weight = 1'b0; bus.gemm_sel = '0;
    #2 rst = 1'b1;
    #1;
    check_output("rst_count", 64'(count), 64'd0);
    check_output("rst_sp_valid", 64'(bus.sp_valid), 64'd0);
    check_output("rst_mls_ready", 64'(bus.mls_ready), 64'd1);
    check_output("rst_gemm_ready", 64'(bus.gemm_ready), 64'd1);
    step(); step();
    rst = 1'b0;

    $display("[TB] single MLS load");
    apply_mls(2'b01, 4'd3, 32'h0000_1000, 11'h7FF, 5'd4);
    sb.push_back({2'b01, 4'b0011, 32'h0000_0FFF, 5'b00100});
    step(); idle();
    check_output("mls_count", 64'(count), 64'd1);
    check_output("mls_sp_valid", 64'(bus.sp_valid), 64'd1);
    check_output("mls_head", 64'(bus.sp_data), 64'({2'b01, 4'b0011, 32'h0000_0FFF, 5'b00100}));
    drain();

    $display("[TB] GEMM and MLS priority");
    apply_gemm(1'b1, 16'hBEEF);
    #1 check_output("gemm_ready_alone", 64'(bus.gemm_ready), 64'd1);
    sb.push_back({2'b11, 4'b1000, 32'h0000_BEEF, 5'd0});
    step(); idle();
    apply_gemm(1'b0, 16'h1234);
    apply_mls(2'b10, 4'd5, 32'h0000_2000, 11'h010, 5'd1);
    #1 check_output("gemm_blocked", 64'(bus.gemm_ready), 64'd0);
    sb.push_back({2'b10, 4'd5, 32'h0000_2010, 5'd1});
    step();
    bus.mls_valid = 1'b0;
    sb.push_back({2'b11, 4'b0000, 32'h0000_1234, 5'd0});
    step(); idle();
    check_output("prio_count", 64'(count), 64'd3);
    drain();

    $display("[TB] fill to full");
    for (int i = 0; i < 8; i++) begin
      apply_mls(fill_ls[i], 4'(i), fill_rs[i], fill_imm[i], fill_st[i]);
      sb.push_back({fill_ls[i], 4'(i), fill_addr[i], fill_st[i]});
      step();
      check_output("fill_count", 64'(count), 64'(i + 1));
      check_output("fill_af", 64'(almost_full), (i + 1 >= 6) ? 64'd1 : 64'd0);
    end
    idle();
    #1 check_output("full_mls_ready", 64'(bus.mls_ready), 64'd0);
    apply_mls(2'b01, 4'd9, 32'hCAFE_0000, 11'h004, 5'd7);
    bus.sp_ready = 1'b1;
    #1 check_output("full_pop_reject", 64'(bus.mls_ready), 64'd0);
    step();
    bus.sp_ready = 1'b0;
    #1 check_output("after_pop_ready", 64'(bus.mls_ready), 64'd1);
    sb.push_back({2'b01, 4'd9, 32'hCAFE_0004, 5'd7});
    step(); idle();
    check_output("refill_count", 64'(count), 64'd8);
    drain();

    $display("[TB] streaming");
    bus.sp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      apply_gemm(k[0], 16'(16'hA000 + k));
      sb.push_back({2'b11, k[0], 3'b000, 16'd0, 16'(16'hA000 + k), 5'd0});
      step();
      check_output("stream_count", 64'(count), 64'd1);
      check_output("stream_valid", 64'(bus.sp_valid), 64'd1);
    end
    idle();
    step();
    check_output("stream_end", 64'(count), 64'd0);
    bus.sp_ready = 1'b0;

    $display("[TB] illegal op");
    apply_mls(2'b11, 4'd1, 32'h0, 11'h0, 5'd0);
    apply_gemm(1'b0, 16'h5555);
    #1 check_output("illegal_gemm_blk", 64'(bus.gemm_ready), 64'd0);
    step(); idle();
    check_output("illegal_pulse", 64'(illegal_op), 64'd1);
    check_output("illegal_count", 64'(count), 64'd0);
    step();
    check_output("illegal_clear", 64'(illegal_op), 64'd0);

    $display("[TB] flush");
    for (int i = 0; i < 5; i++) begin
      apply_mls(2'b01, 4'(i), 32'h0000_4000, 11'(i), 5'd2);
      sb.push_back({2'b01, 4'(i), 32'h0000_4000 + 32'(i), 5'd2});
      step();
    end
    flush = 1'b1;
    bus.sp_ready = 1'b1;
    apply_mls(2'b10, 4'd7, 32'h0000_9000, 11'h0, 5'd0);
    #1 check_output("flush_mls_ready", 64'(bus.mls_ready), 64'd0);
    step();
    flush = 1'b0; bus.sp_ready = 1'b0; idle();
    sb.delete();
    check_output("flush_count", 64'(count), 64'd0);
    check_output("flush_sp_valid", 64'(bus.sp_valid), 64'd0);
    flush = 1'b1;
    apply_mls(2'b00, 4'd0, 32'h0, 11'h0, 5'd0);
    step();
    flush = 1'b0; idle();
    check_output("flush_no_illegal", 64'(illegal_op), 64'd0);

    $display("[TB] async reset mid-burst");
    for (int i = 0; i < 6; i++) begin
      apply_mls(2'b10, 4'(i), 32'h0000_8000, 11'h0, 5'd1);
      step();
    end
    apply_mls(2'b00, 4'd0, 32'h0, 11'h0, 5'd0);
    step(); idle();
    check_output("pre_rst_af", 64'(almost_full), 64'd1);
    check_output("pre_rst_illegal", 64'(illegal_op), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_output("arst_count", 64'(count), 64'd0);
    check_output("arst_sp_valid", 64'(bus.sp_valid), 64'd0);
    check_output("arst_af", 64'(almost_full), 64'd0);
    check_output("arst_illegal", 64'(illegal_op), 64'd0);
    check_output("arst_gemm_ready", 64'(bus.gemm_ready), 64'd1);
    step();
    rst = 1'b0;
    apply_mls(2'b01, 4'd15, 32'hFFFF_FFFF, 11'h001, 5'd9);
    sb.push_back({2'b01, 4'd15, 32'h0000_0000, 5'd9});
    step(); idle();
    check_output("post_rst_count", 64'(count), 64'd1);
    drain();
    step();
    check_output("sb_leftover", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/sp_req_queue.md
Name: sp_req_queue

Overview:
- Buffers and packs scratchpad requests issued by the execute stage's matrix load/store (MLS) and GEMM functional units.
- Sits directly downstream of execute and upstream of the scratchpad controller.
- Computes the MLS effective address, formats each request into a fixed 43-bit entry, and queues entries in a FIFO.
- Back-pressures execute when the FIFO is full, and presents entries to the scratchpad with a valid/ready handshake.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, at least 2
AF_THRESH, 6, occupancy at or above which almost_full asserts; must be 1..DEPTH

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  asynchronous, active-high reset
flush  in  1  synchronous queue clear (misprediction/exception squash)
mls_valid  in  1  MLS request present
mls_ls  in  2  01 = load, 10 = store; 00 and 11 are illegal
mls_rd  in  4  matrix register id
mls_rs  in  32  base address
mls_imm  in  11  signed address offset
mls_stride  in  5  row stride
mls_ready  out  1  MLS request accepted this cycle when mls_valid is also high
gemm_valid  in  1  GEMM request present
gemm_new_weight  in  1  reload weights before this GEMM
gemm_sel  in  16  GEMM buffer select
gemm_ready  out  1  GEMM request accepted this cycle when gemm_valid is also high
sp_valid  out  1  head entry valid
sp_data  out  43  head entry
sp_ready  in  1  scratchpad consumes the head entry
count  out  $clog2(DEPTH)+1  current occupancy
almost_full  out  1  count >= AF_THRESH
illegal_op  out  1  one-cycle pulse when an illegal MLS op is dropped

Behaviour:
- Entry format, MSB first, 43 bits: {op[1:0], md[3:0], addr[31:0], stride[4:0]}.
  - MLS entry: op = mls_ls, md = mls_rd, addr = mls_rs + sign_extend(mls_imm), stride = mls_stride.
  - Address addition is modulo 2^32; carry-out is discarded.
  - GEMM entry: op = 11, md = {gemm_new_weight, 3'b000}, addr = {16'd0, gemm_sel}, stride = 0.
- full = (count == DEPTH), derived from registered state only.
- mls_ready = !full && !flush.
- gemm_ready = !full && !flush && !mls_valid. MLS has strict priority; at most one push per cycle.
- Illegal MLS op (mls_valid=1, mls_ls = 00 or 11, mls_ready=1):
  - request is consumed and not written;
  - illegal_op is registered high for exactly the next cycle;
  - a GEMM request stays blocked that cycle.
- FIFO is first-word-fall-through with no bypass.
  - An entry pushed in cycle N is visible on sp_valid/sp_data in cycle N+1 at the earliest.
  - sp_valid = (count != 0); sp_data = mem[rd_ptr] and is stable while sp_valid=1 and sp_ready=0.
- Pop occurs when sp_valid && sp_ready.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full with a pop in the same cycle: the push is still rejected, because ready is computed from registered count. The slot is usable next cycle.
- Empty with a push in the same cycle: the pop is impossible because sp_valid=0.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. count saturates nowhere; an overflow or underflow is a design bug and the verification engineer must assert against it.
- flush=1:
  - next cycle count=0, rd_ptr=wr_ptr=0, sp_valid=0;
  - any push that cycle is ignored (ready=0);
  - a same-cycle sp_ready handshake counts as delivered to the consumer;
  - illegal_op does not fire.
- RST asserted, including mid-operation: immediately count=0, pointers=0, sp_valid=0, almost_full=0, illegal_op=0.
  - mls_ready and gemm_ready read 1 whenever flush=0, since they are combinational from the cleared state.
  - FIFO storage is not reset; sp_data is don't-care while sp_valid=0.
- almost_full is combinational from registered count.

Test Plan:
- Reset, then MLS load: mls_ls=01, rd=3, rs=0x1000, imm=0x7FF (-1), stride=4 → next cycle sp_valid=1, sp_data={01,0011,0x00000FFF,00100}, count=1.
- GEMM: new_weight=1, sel=0xBEEF, with mls_valid=0 → sp_data={11,1000,0x0000BEEF,00000}. Simultaneously assert mls_valid with a legal MLS → gemm_ready=0, MLS entry queued first, GEMM queued next cycle.
- Fill 8 entries with sp_ready=0 → count=8, almost_full high from count=6, mls_ready=0.
  - Same cycle as the first pop with a push offered → push rejected.
  - Next cycle → push accepted, count returns to 8.
  - Drain → entries emerge in push order across pointer wrap.
- Steady streaming with sp_ready=1 and a push every cycle → count holds at 1, one entry delivered per cycle, no bubbles after the first.
- mls_ls=11 with valid → no entry written, illegal_op pulses for 1 cycle, count unchanged.
- 5 entries queued, assert flush with a concurrent push and pop → next cycle count=0, sp_valid=0. Assert RST mid-burst → all outputs return to reset values asynchronously.
